// File: rtl/prbs4_checker.sv
// PRBS4 (x^4+x^3+1) sequence checker: locks onto a received 4-bit LFSR
// state stream, then flags and counts words that deviate from it.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-low reset
//   in_valid   in_data carries a sequence word this cycle
//   in_data    received 4-bit LFSR state word
//   clear_cnt  synchronous clear of err_count (wins over increment)
//   locked     checker is synchronized to the sequence
//   err_pulse  one-cycle flag for a mismatched word while locked
//   err_count  saturating count of mismatched words while locked
module prbs4_checker #(
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 3,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [3:0]       in_data,
    input  logic             clear_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [3:0] LOCK_C = 4'(LOCK_COUNT);
    localparam logic [3:0] LOSS_C = 4'(LOSS_COUNT);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t     state;
    logic       have_prev;
    logic [3:0] prev;
    logic [3:0] expected;
    logic [3:0] match_cnt;
    logic [3:0] miss_cnt;

    logic [3:0] match_inc;
    logic [3:0] miss_inc;
    logic       seq_hit;

    function automatic logic [3:0] lfsr_next(input logic [3:0] s);
        return {s[2:0], s[3] ^ s[2]};
    endfunction

    // The all-zero word is the LFSR lock-up state and never matches.
    always_comb begin
        match_inc = match_cnt + 4'd1;
        miss_inc  = miss_cnt + 4'd1;
        seq_hit   = (in_data == lfsr_next(prev)) && (in_data != 4'd0);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= SEARCH;
            have_prev <= 1'b0;
            prev      <= 4'd0;
            expected  <= 4'd0;
            match_cnt <= 4'd0;
            miss_cnt  <= 4'd0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            err_pulse <= 1'b0;

            if (in_valid) begin
                unique case (state)
                    SEARCH: begin
                        prev <= in_data;
                        if (!have_prev) begin
                            // First word only seeds the predictor.
                            have_prev <= 1'b1;
                            match_cnt <= 4'd0;
                        end else if (seq_hit) begin
                            if (match_inc == LOCK_C) begin
                                state     <= LOCKED;
                                locked    <= 1'b1;
                                expected  <= lfsr_next(in_data);
                                match_cnt <= 4'd0;
                                miss_cnt  <= 4'd0;
                            end else begin
                                match_cnt <= match_inc;
                            end
                        end else begin
                            match_cnt <= 4'd0;
                        end
                    end
                    LOCKED: begin
                        // Free-running reference: advance even on error.
                        expected <= lfsr_next(expected);
                        if (in_data == expected) begin
                            miss_cnt <= 4'd0;
                        end else begin
                            err_pulse <= 1'b1;
                            if (err_count != CNT_MAX) begin
                                err_count <= err_count + CNT_W'(1);
                            end
                            if (miss_inc == LOSS_C) begin
                                state     <= SEARCH;
                                locked    <= 1'b0;
                                have_prev <= 1'b0;
                                match_cnt <= 4'd0;
                                miss_cnt  <= 4'd0;
                            end else begin
                                miss_cnt <= miss_inc;
                            end
                        end
                    end
                    default: begin
                        state  <= SEARCH;
                        locked <= 1'b0;
                    end
                endcase
            end

            // Clear overrides any increment made above in the same cycle.
            if (clear_cnt) begin
                err_count <= '0;
            end
        end
    end

endmodule

// File: doc/prbs4_checker.md
PRBS4_CHECKER -- requirements
Module: prbs4_checker

Interface
REQ-001 Parameter LOCK_COUNT, default 4: consecutive matching words required to declare lock (legal range 1..15).
REQ-002 Parameter LOSS_COUNT, default 3: consecutive mismatching words while locked that force loss of lock (legal range 1..15).
REQ-003 Parameter CNT_W, default 16: width of the error counter.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-low reset.
REQ-006 in_valid  input  1  in_data holds a sequence word this cycle.
REQ-007 in_data  input  4  received 4-bit LFSR state word.
REQ-008 clear_cnt  input  1  synchronous clear of err_count.
REQ-009 locked  output  1  checker is synchronized to the sequence (registered).
REQ-010 err_pulse  output  1  one-cycle flag for a mismatched word while locked (registered).
REQ-011 err_count  output  CNT_W  saturating count of mismatched words (registered).

Function
REQ-012 The checker SHALL use next(s) = {s[2:0], s[3]^s[2]}, i.e. x^4+x^3+1, with a maximal period of 15.
REQ-013 The checker SHALL implement a two-state FSM: SEARCH (the reset state) and LOCKED.
REQ-014 With in_valid low, the checker SHALL hold all state, clear err_pulse, and leave counters unchanged.
REQ-015 In SEARCH, the first valid word after reset or after loss of lock SHALL only be stored as prev, with match_cnt=0.
REQ-016 In SEARCH, a valid word equal to next(prev) and nonzero SHALL increment match_cnt; otherwise match_cnt SHALL go to 0; in both cases prev takes in_data.
REQ-017 A word of 4'b0000 SHALL never count as a match (LFSR lock-up state).
REQ-018 When the increment in REQ-016 makes match_cnt equal LOCK_COUNT, the FSM SHALL enter LOCKED with expected = next(in_data), and locked SHALL be 1 in the following cycle.
REQ-019 In LOCKED, each valid word SHALL be compared with expected, and expected SHALL advance to next(expected) regardless of the result (free-running reference, no resync on error).
REQ-020 In LOCKED, a mismatch SHALL set err_pulse=1 for the next cycle, increment err_count (saturating at all-ones), and increment miss_cnt.
REQ-021 In LOCKED, a match SHALL reset miss_cnt to 0.
REQ-022 When miss_cnt reaches LOSS_COUNT, the FSM SHALL return to SEARCH, with locked=0 in the following cycle and match_cnt=0; the error that triggered the loss SHALL still be counted and pulsed.
REQ-023 In SEARCH, mismatches SHALL never assert err_pulse or change err_count.
REQ-024 clear_cnt SHALL have priority over increment: when both occur in one cycle, err_count becomes 0 and err_pulse is still asserted.
REQ-025 Latency from a valid input word to its effect on any output SHALL be exactly one clock.

Reset
REQ-026 While rst=0 at a rising edge, the checker SHALL set FSM=SEARCH, locked=0, err_pulse=0, err_count=0, match_cnt=0, miss_cnt=0, and prev/expected=0.
REQ-027 Reset asserted mid-lock SHALL abandon lock immediately, and the first post-reset valid word SHALL be treated per REQ-015.

Verification
REQ-028 The bench SHALL hold rst=0 for 2 cycles with random in_data -> locked=0, err_pulse=0, err_count=0 throughout.
REQ-029 The bench SHALL drive valid words 0001,0010,0100,1001,0011 back-to-back -> locked=1 the cycle after 0011, err_count=0.
REQ-030 While locked, the bench SHALL replace expected 0110 with 1111 and then continue 1101,1010 -> exactly one err_pulse, err_count=1, locked stays 1.
REQ-031 While locked, the bench SHALL send 3 consecutive wrong words -> err_count +3, locked=0 the cycle after the 3rd word, and relock after 5 further correct words.
REQ-032 The bench SHALL drive a stream of 20 valid 0000 words, plus gaps with in_valid=0 inside a correct sequence -> the all-zero stream never locks; the gaps do not break lock or the match count.
REQ-033 The bench SHALL assert clear_cnt in the same cycle as a locked mismatch with err_count=5 -> err_count=0, err_pulse=1; with CNT_W=2 forced errors, err_count saturates at 3.
